// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - sequenced up-counter with one-shot/periodic modes and sticky interrupt
module counter_ctrl #(
  parameter int                WIDTH        = 4,
  parameter logic [WIDTH-1:0]  DEFAULT_TERM = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_term,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             irq,
  output logic             overrun,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             irq_q, irq_d;
  logic             ovr_q, ovr_d;
  logic             err_q, err_d;
  logic             hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      term_q  <= DEFAULT_TERM;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    hit     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // stop beats start even here, so a simultaneous pair leaves us idle
        if (start && !stop) begin
          state_d = ST_RUN;
          count_d = '0;
          mode_d  = mode;
        end
        if (cfg_we) term_d = cfg_term;
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (count_q != term_q) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          hit = 1'b1;
          if (mode_q) count_d = '0;
          else        state_d = ST_DONE;
        end
        if (cfg_we) err_d = 1'b1;
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (start) begin
          state_d = ST_RUN;
        end
        if (cfg_we) err_d = 1'b1;
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (start) begin
          state_d = ST_RUN;
          count_d = '0;
          mode_d  = mode;
        end
        if (cfg_we) term_d = cfg_term;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // A terminal hit always sets irq; an ack coinciding with a hit only clears overrun.
  always_comb begin
    tc_d  = hit;
    irq_d = irq_q;
    ovr_d = ovr_q;
    if (hit) begin
      irq_d = 1'b1;
      if (irq_ack)    ovr_d = 1'b0;
      else if (irq_q) ovr_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  assign busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);

  assign count    = count_q;
  assign busy     = busy_q;
  assign tc_pulse = tc_q;
  assign irq      = irq_q;
  assign overrun  = ovr_q;
  assign cfg_err  = err_q;

endmodule
